// File: rtl/uart_pkg.sv
// Shared UART definitions: state codes, widths and parity helpers.
// Imported by both the transmitter and the receiver side.
package uart_pkg;

  localparam int DEFAULT_CLK_DIV = 434;
  localparam int DATA_BITS       = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic parity_of(
    input logic [DATA_BITS-1:0] d,
    input logic                 odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter; bit_tick marks the last cycle of a bit.
// Wraps on its own, so consecutive bits need no restart.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = (cnt_q == LAST);

  // next count: hold at zero on restart, wrap at the end of a bit
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || bit_tick) begin
      cnt_d = '0;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter, LSB first, optional parity, 1 or 2 stops.
// A one-byte holding register lets frames run back to back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic ODD_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic LAST_SB = 1'(STOP_BITS - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [2:0] idx_q, idx_d;
  logic       stop_q, stop_d;
  logic       txd_q, txd_d;

  logic bit_tick;
  logic accept;
  logic load;
  logic last_stop;

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state_q == ST_IDLE),
    .bit_tick (bit_tick)
  );

  assign accept    = tx_valid & ~hold_full_q;
  assign last_stop = (stop_q == LAST_SB);

  assign tx_ready = ~hold_full_q;
  assign txd      = txd_q;
  assign tx_busy  = (state_q != ST_IDLE) | hold_full_q;
  assign tx_done  = (state_q == ST_STOP) & bit_tick & last_stop;

  // frame sequencing, holding register and line value
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    txd_d       = txd_q;
    load        = 1'b0;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        load  = hold_full_q;
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (last_stop) begin
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (load) begin
      state_d     = ST_START;
      shift_d     = hold_q;
      par_d       = parity_of(hold_q, ODD_SEL);
      hold_full_d = 1'b0;
      txd_d       = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      txd_q       <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover 8N1, even/odd
// parity and two stop bits; expected line bits flow through a queue.
module tb_uart_tx;

  localparam int CD = 4;

  function automatic int pen(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic int pod(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int sb(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid [4];
  logic [7:0] data  [4];
  logic       ready [4];
  logic       txd   [4];
  logic       busy  [4];
  logic       done  [4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      uart_tx #(
        .CLK_DIV    (CD),
        .STOP_BITS  (sb(g)),
        .PARITY_EN  (pen(g)),
        .PARITY_ODD (pod(g))
      ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (valid[g]),
        .tx_data  (data[g]),
        .tx_ready (ready[g]),
        .txd      (txd[g]),
        .tx_busy  (busy[g]),
        .tx_done  (done[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int k, input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pen(k) != 0) exp_q.push_back((pod(k) != 0) ? ~^d : ^d);
    for (int i = 0; i < sb(k); i++) exp_q.push_back(1'b1);
  endtask

  task automatic send(input int k, input logic [7:0] d,
                      input string tag);
    chk({tag, "_rdy"}, 32'(ready[k]), 1);
    valid[k] = 1'b1;
    data[k]  = d;
    push_frame(k, d);
    step();
    valid[k] = 1'b0;
    data[k]  = 8'($urandom);
    chk({tag, "_rdy_lo"}, 32'(ready[k]), 0);
    chk({tag, "_busy"}, 32'(busy[k]), 1);
    chk({tag, "_idle"}, 32'(txd[k]), 1);
  endtask

  task automatic expect_frame(input int k, input int gap,
                              input int send_at, input logic [7:0] sd,
                              input int ign_at, input int abort_at,
                              input string tag);
    int   nb;
    int   t;
    logic e;
    nb = 9 + pen(k) + sb(k);
    t  = 0;
    while (txd[k] !== 1'b0 && t < 200) begin
      step();
      t++;
    end
    chk({tag, "_gap"}, 32'(t), 32'(gap));
    for (int b = 0; b < nb; b++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      for (int c = 0; c < CD; c++) begin
        int cyc;
        cyc = b * CD + c;
        if (cyc == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk({tag, "_rst_txd"}, 32'(txd[k]), 1);
          chk({tag, "_rst_done"}, 32'(done[k]), 0);
          chk({tag, "_rst_rdy"}, 32'(ready[k]), 1);
          chk({tag, "_rst_busy"}, 32'(busy[k]), 0);
          exp_q.delete();
          return;
        end
        chk({tag, "_txd"}, 32'(txd[k]), 32'(e));
        chk({tag, "_done"}, 32'(done[k]),
            32'(b == nb - 1 && c == CD - 1));
        if (send_at >= 0 && cyc > send_at)
          chk({tag, "_rdy_hold"}, 32'(ready[k]), 0);
        if (cyc == send_at) begin
          chk({tag, "_rdy_send"}, 32'(ready[k]), 1);
          valid[k] = 1'b1;
          data[k]  = sd;
          push_frame(k, sd);
        end
        if (cyc == ign_at) begin
          valid[k] = 1'b1;
          data[k]  = 8'h5A;
        end
        step();
        valid[k] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      valid[k] = 1'b1;
      data[k]  = 8'hC3;
    end
    rst_n = 1'b0;
    repeat (5) begin
      step();
      for (int k = 0; k < 4; k++) begin
        chk("rst_txd", 32'(txd[k]), 1);
        chk("rst_rdy", 32'(ready[k]), 1);
        chk("rst_busy", 32'(busy[k]), 0);
        chk("rst_done", 32'(done[k]), 0);
      end
    end
    for (int k = 0; k < 4; k++) valid[k] = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy[0]), 0);
    chk("post_rst_rdy", 32'(ready[0]), 1);

    send(0, 8'hA5, "a5");
    expect_frame(0, 1, -1, 8'h00, -1, -1, "a5");
    chk("a5_busy_after", 32'(busy[0]), 0);
    chk("a5_txd_after", 32'(txd[0]), 1);

    send(0, 8'h00, "b2b1");
    expect_frame(0, 1, 12, 8'hFF, 20, -1, "b2b1");
    expect_frame(0, 0, -1, 8'h00, -1, -1, "b2b2");
    chk("b2b_busy_after", 32'(busy[0]), 0);

    send(1, 8'h03, "par_even03");
    expect_frame(1, 1, -1, 8'h00, -1, -1, "par_even03");
    send(2, 8'h07, "par_odd07");
    expect_frame(2, 1, -1, 8'h00, -1, -1, "par_odd07");
    send(2, 8'h03, "par_odd03");
    expect_frame(2, 1, -1, 8'h00, -1, -1, "par_odd03");
    chk("par_busy_after", 32'(busy[2]), 0);

    send(0, 8'h96, "fin1");
    expect_frame(0, 1, 39, 8'h4E, -1, -1, "fin1");
    chk("fin_gap_rdy", 32'(ready[0]), 0);
    chk("fin_gap_txd", 32'(txd[0]), 1);
    expect_frame(0, 1, -1, 8'h00, -1, -1, "fin2");

    send(3, 8'h55, "s2a");
    expect_frame(3, 1, 36, 8'hAA, -1, -1, "s2a");
    expect_frame(3, 0, -1, 8'h00, -1, -1, "s2b");
    chk("s2_busy_after", 32'(busy[3]), 0);

    send(0, 8'h3C, "abort");
    expect_frame(0, 1, -1, 8'h00, -1, 17, "abort");
    step();
    chk("abort_hold_done", 32'(done[0]), 0);
    chk("abort_hold_txd", 32'(txd[0]), 1);
    step();
    rst_n = 1'b1;
    step();
    chk("abort_after_busy", 32'(busy[0]), 0);
    send(0, 8'h81, "clean");
    expect_frame(0, 1, -1, 8'h00, -1, -1, "clean");
    chk("clean_busy_after", 32'(busy[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter, LSB first: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Pairs with the existing UART receiver on the cortex_m0 peripheral bus side.
- Has an internal baud divider, so no external bit tick is needed.
- One-entry holding register in front of the shift register allows back-to-back frames with no idle gap.

Parameters:
- CLK_DIV, 434, clk cycles per bit (50 MHz / 115200); legal range is 2 or more.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- PARITY_EN, 0, 1 inserts a parity bit after D7.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- tx_valid  input  1  write request for tx_data
- tx_data  input  8  byte to send; sampled only on accept
- tx_ready  output  1  holding register empty; accept = tx_valid & tx_ready
- txd  output  1  serial line; idles high; registered output
- tx_busy  output  1  high while a frame is in flight or a byte is held
- tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit

Behaviour:
- Reset (async) forces:
  - txd=1, tx_ready=1, tx_busy=0, tx_done=0
  - state=IDLE, holding register empty
  - baud counter=0, shift register=0
- Reset mid-frame aborts the frame immediately: txd goes high, no tx_done, the held byte is discarded.
- Handshake:
  - On an accept edge, tx_data is written to the holding register (hold_full=1) and tx_ready drops.
  - tx_valid while tx_ready=0 is ignored; there is no overwrite.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1.
  - If hold_full: at the next edge go to START, load the shifter, clear hold_full, set txd<=0.
  - txd therefore falls one clk after the accept edge.
- Bit timing:
  - The baud counter runs 0..CLK_DIV-1 and restarts at every bit boundary.
  - Every bit, including each stop bit, lasts exactly CLK_DIV cycles.
  - Counter width is $clog2(CLK_DIV).
- START -> DATA after CLK_DIV cycles.
- DATA:
  - Shifts out D0..D7; a 3-bit index counts bits.
  - After D7: go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - Bit value is ^data for even parity, ~^data for odd.
  - Parity is computed from the byte captured at shifter load.
- STOP:
  - txd=1 for STOP_BITS*CLK_DIV cycles.
  - On the final cycle of the last stop bit, tx_done=1 for that one cycle.
  - If hold_full on that cycle: go directly to START (no idle gap), load the shifter, clear hold_full.
  - Otherwise go to IDLE.
- Simultaneous accept on the final stop cycle with the holding register empty:
  - The byte is written to the holding register; the state goes to IDLE.
  - START follows at the next edge, giving exactly 1 idle-high cycle.
- Frame length = (1+8+PARITY_EN+STOP_BITS)*CLK_DIV cycles.
- tx_busy = (state!=IDLE) | hold_full; it is combinational from registers.
- tx_data may change freely when not being accepted.

Decomposition:
- uart_pkg (shared with the receiver): state encoding constants, DEFAULT_CLK_DIV, DATA_BITS=8, parity-mode constants.
- Sub-module uart_baud_gen:
  - Restartable CLK_DIV counter.
  - Inputs: clk, rst_n, restart. Output: bit_tick, high on the last cycle of each bit period.
  - Reusable by a future oversampling receiver.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with tx_valid=1 -> txd=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; no accept.
- CLK_DIV=4, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_done pulses once, 40 cycles after txd falls; tx_busy low the cycle after.
- CLK_DIV=4, accept 0x00, then 0xFF during bit D2 -> tx_ready low until 0xFF loads at the end of frame 1; frame 2 start bit immediately follows stop bit 1 with no gap; two tx_done pulses 40 cycles apart.
- PARITY_EN=1: 0x03 with PARITY_ODD=0 -> parity bit 0; 0x07 with PARITY_ODD=1 -> parity bit 0; 0x03 with PARITY_ODD=1 -> parity bit 1; frame is 44 cycles at CLK_DIV=4.
- STOP_BITS=2, CLK_DIV=4, 0x55 -> txd high for 8 cycles after D7; tx_done on the 8th; a new accept during the first stop bit starts immediately after.
- Assert rst_n low during D3 of 0x3C -> txd=1 asynchronously, no tx_done; after release, 0x81 is sent as a clean 40-cycle frame.
